// File: rtl/uart_frame_assembler_if.sv
// Byte-level signal bundle between Uart_Rx/Uart_Tx, the frame assembler and the CNN input buffer.
// The master modport is the assembler's view of the bundle.
interface uart_frame_assembler_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        RxByte;
    logic              RxBusy;
    logic              TxBusy;
    logic              TxSend;
    logic [7:0]        TxByte;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [7:0]        WrData;
    logic              FrameDone;
    logic              FrameErr;

    modport master (
        input  RxByte, RxBusy, TxBusy,
        output TxSend, TxByte, WrEn, WrAddr, WrData, FrameDone, FrameErr
    );

    modport slave (
        output RxByte, RxBusy, TxBusy,
        input  TxSend, TxByte, WrEn, WrAddr, WrData, FrameDone, FrameErr
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// Parses SYNC/LEN/payload/CSUM frames from Uart_Rx into buffer writes and requests an ACK/NAK byte.
// Optional inter-byte timeout is compiled in with `define FRAME_TIMEOUT_EN.
module uart_frame_assembler #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] ACK_BYTE  = 8'h06,
    parameter logic [7:0] NAK_BYTE  = 8'h15,
    parameter int         ADDR_W    = 8
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter logic [19:0] TIMEOUT_CLK = 20'd86800
`endif
) (
    input logic CLK,
    input logic Reset_n,
    uart_frame_assembler_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_RESP} state_t;

    state_t            state, state_nxt;
    logic              busy_q;
    logic              rx_v;
    logic [7:0]        len_q, len_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic [8:0]        cnt_inc;
    logic [7:0]        sum_q, sum_nxt;
    logic [7:0]        resp_q, resp_nxt;
    logic              wr_en_q, wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
    logic [7:0]        wr_data_q, wr_data_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              tx_send_q, tx_send_nxt;
    logic [7:0]        tx_byte_q, tx_byte_nxt;

    assign rx_v = busy_q & ~bus.RxBusy;
    // Nine-bit increment so that len=255 is reached without cnt wrapping first.
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

`ifdef FRAME_TIMEOUT_EN
    logic [19:0] to_cnt_q, to_cnt_nxt;
    logic        timed_out;

    assign timed_out = (to_cnt_q == TIMEOUT_CLK);
`endif

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        cnt_nxt     = cnt_q;
        sum_nxt     = sum_q;
        resp_nxt    = resp_q;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_q;
        wr_data_nxt = wr_data_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        tx_send_nxt = 1'b0;
        tx_byte_nxt = tx_byte_q;

        case (state)
            S_IDLE: begin
                if (rx_v && bus.RxByte == SYNC_BYTE)
                    state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_v) begin
                    len_nxt = bus.RxByte;
                    if (bus.RxByte == 8'd0) begin
                        err_nxt   = 1'b1;
                        resp_nxt  = NAK_BYTE;
                        state_nxt = S_RESP;
                    end else begin
                        cnt_nxt   = '0;
                        sum_nxt   = '0;
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_v) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = ADDR_W'(cnt_q);
                    wr_data_nxt = bus.RxByte;
                    sum_nxt     = sum_q + bus.RxByte;
                    cnt_nxt     = cnt_inc[7:0];
                    if (cnt_inc == {1'b0, len_q})
                        state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_v) begin
                    if (bus.RxByte == sum_q) begin
                        done_nxt = 1'b1;
                        resp_nxt = ACK_BYTE;
                    end else begin
                        err_nxt  = 1'b1;
                        resp_nxt = NAK_BYTE;
                    end
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (!bus.TxBusy) begin
                    tx_send_nxt = 1'b1;
                    tx_byte_nxt = resp_q;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

`ifdef FRAME_TIMEOUT_EN
        // Mid-frame states act on nothing when rx_v is low, so the timeout can override them here.
        to_cnt_nxt = '0;
        if ((state == S_LEN || state == S_PAYLOAD || state == S_CSUM) && !rx_v) begin
            if (timed_out) begin
                err_nxt   = 1'b1;
                state_nxt = S_IDLE;
            end else begin
                to_cnt_nxt = to_cnt_q + 20'd1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            resp_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tx_send_q <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state     <= state_nxt;
            busy_q    <= bus.RxBusy;
            len_q     <= len_nxt;
            cnt_q     <= cnt_nxt;
            sum_q     <= sum_nxt;
            resp_q    <= resp_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            tx_send_q <= tx_send_nxt;
            tx_byte_q <= tx_byte_nxt;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_nxt;
    end
`endif

    assign bus.WrEn      = wr_en_q;
    assign bus.WrAddr    = wr_addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.FrameDone = done_q;
    assign bus.FrameErr  = err_q;
    assign bus.TxSend    = tx_send_q;
    assign bus.TxByte    = tx_byte_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed-frame bench for uart_frame_assembler with a queue-based frame model checked every cycle.
// Define FRAME_TIMEOUT_EN to also exercise the inter-byte timeout (shortened via parameter override).
module tb_uart_frame_assembler;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
`ifdef FRAME_TIMEOUT_EN
    localparam int TO = 200;
`endif

    logic CLK = 1'b0;
    logic Reset_n = 1'b0;

    uart_frame_assembler_if #(.ADDR_W(8)) bus ();

    uart_frame_assembler #(
        .SYNC_BYTE(SYNC),
        .ACK_BYTE (ACK),
        .NAK_BYTE (NAK),
        .ADDR_W   (8)
`ifdef FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CLK(20'(TO))
`endif
    ) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Frame-level model: bytes after SYNC are collected in a queue and interpreted by position.
    logic       m_in_frame = 1'b0;
    logic [7:0] m_frame[$];
    logic       m_resp_pending = 1'b0;
    logic [7:0] m_resp = 8'h00;
    logic       m_byte_now = 1'b0;
    int         m_quiet = 0;

    logic       e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0, e_tx = 1'b0;
    logic [7:0] e_addr = 8'h00, e_data = 8'h00, e_tx_byte = 8'h00;

    int         wr_count = 0, done_count = 0, err_count = 0, tx_count = 0;
    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [7:0] last_tx = 8'h00;

    task automatic model_reset();
        m_in_frame     = 1'b0;
        m_frame        = {};
        m_resp_pending = 1'b0;
        m_resp         = 8'h00;
        m_byte_now     = 1'b0;
        m_quiet        = 0;
        e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_tx = 1'b0;
        e_addr = 8'h00; e_data = 8'h00; e_tx_byte = 8'h00;
    endtask

    task automatic model_feed(input logic [7:0] b);
        int n;
        logic [7:0] s;
        m_byte_now = 1'b1;
        if (m_resp_pending || e_tx) begin
            // response outstanding: byte is dropped
        end else if (!m_in_frame) begin
            if (b == SYNC) begin
                m_in_frame = 1'b1;
                m_frame    = {};
                m_quiet    = 0;
            end
        end else begin
            m_quiet = 0;
            m_frame.push_back(b);
            n = m_frame.size();
            if (n == 1) begin
                if (b == 8'h00) begin
                    e_err = 1'b1;
                    m_resp = NAK;
                    m_resp_pending = 1'b1;
                    m_in_frame = 1'b0;
                end
            end else if (n <= int'(m_frame[0]) + 1) begin
                e_wr   = 1'b1;
                e_addr = 8'(n - 2);
                e_data = b;
            end else begin
                s = 8'h00;
                for (int i = 1; i < n - 1; i++) s = s + m_frame[i];
                if (s == b) begin
                    e_done = 1'b1;
                    m_resp = ACK;
                end else begin
                    e_err  = 1'b1;
                    m_resp = NAK;
                end
                m_resp_pending = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!Reset_n) begin
            check("rst_WrEn", bus.WrEn, 0);
            check("rst_FrameDone", bus.FrameDone, 0);
            check("rst_FrameErr", bus.FrameErr, 0);
            check("rst_TxSend", bus.TxSend, 0);
            check("rst_TxByte", bus.TxByte, 0);
        end else begin
`ifdef FRAME_TIMEOUT_EN
            if (m_in_frame && !m_byte_now) begin
                m_quiet++;
                if (m_quiet == TO + 1) begin
                    e_err = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
`endif
            check("WrEn", bus.WrEn, e_wr);
            if (e_wr) begin
                check("WrAddr", bus.WrAddr, e_addr);
                check("WrData", bus.WrData, e_data);
            end
            check("FrameDone", bus.FrameDone, e_done);
            check("FrameErr", bus.FrameErr, e_err);
            check("TxSend", bus.TxSend, e_tx);
            check("TxByte", bus.TxByte, e_tx_byte);

            if (bus.WrEn === 1'b1) begin
                wr_count++;
                wr_addr_log.push_back(bus.WrAddr);
                wr_data_log.push_back(bus.WrData);
            end
            if (bus.FrameDone === 1'b1) done_count++;
            if (bus.FrameErr === 1'b1) err_count++;
            if (bus.TxSend === 1'b1) begin
                tx_count++;
                last_tx = bus.TxByte;
            end

            e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_tx = 1'b0;
            m_byte_now = 1'b0;
            if (m_resp_pending && bus.TxBusy === 1'b0) begin
                e_tx = 1'b1;
                e_tx_byte = m_resp;
                m_resp_pending = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.RxByte = b;
        bus.RxBusy = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        bus.RxBusy = 1'b0;
        @(posedge CLK);
        #1;
        model_feed(b);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int         wr0, done0, err0, tx0;
    logic [7:0] q[$];

    task automatic snap();
        wr0 = wr_count; done0 = done_count; err0 = err_count; tx0 = tx_count;
        wr_addr_log = {};
        wr_data_log = {};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.RxByte = 8'h00;
        bus.RxBusy = 1'b0;
        bus.TxBusy = 1'b0;
        model_reset();
        idle(3);
        check("reset_WrAddr", bus.WrAddr, 0);
        check("reset_WrData", bus.WrData, 0);
        Reset_n = 1'b1;
        idle(2);

        // 1: good 3-byte frame
        snap();
        q = {SYNC, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        send_seq(q);
        idle(4);
        check("t1_wr_count", wr_count - wr0, 3);
        check("t1_addr2", wr_addr_log[2], 8'h02);
        check("t1_data0", wr_data_log[0], 8'h10);
        check("t1_data2", wr_data_log[2], 8'h30);
        check("t1_done", done_count - done0, 1);
        check("t1_tx", tx_count - tx0, 1);
        check("t1_txbyte", last_tx, ACK);

        // 2: checksum mismatch
        snap();
        q = {SYNC, 8'h02, 8'h01, 8'h02, 8'h04};
        send_seq(q);
        idle(4);
        check("t2_wr_count", wr_count - wr0, 2);
        check("t2_err", err_count - err0, 1);
        check("t2_done", done_count - done0, 0);
        check("t2_txbyte", last_tx, NAK);

        // 3: junk before SYNC, then LEN=0
        snap();
        q = {8'h00, 8'hFF, SYNC, 8'h00};
        send_seq(q);
        idle(4);
        check("t3_wr_count", wr_count - wr0, 0);
        check("t3_err", err_count - err0, 1);
        check("t3_tx", tx_count - tx0, 1);
        check("t3_txbyte", last_tx, NAK);

        // SYNC value used as payload data
        snap();
        q = {SYNC, 8'h02, SYNC, SYNC, 8'h4A};
        send_seq(q);
        idle(4);
        check("sync_data_wr", wr_count - wr0, 2);
        check("sync_data_txbyte", last_tx, ACK);

        // 4: TxBusy held while response is due; a stray byte is dropped
        snap();
        bus.TxBusy = 1'b1;
        q = {SYNC, 8'h01, 8'h05, 8'h05};
        send_seq(q);
        idle(200);
        send_byte(SYNC);
        idle(295);
        check("t4_no_tx_while_busy", tx_count - tx0, 0);
        bus.TxBusy = 1'b0;
        @(posedge CLK);
        #1;
        check("t4_txsend_now", bus.TxSend, 1);
        check("t4_txbyte_now", bus.TxByte, ACK);
        @(posedge CLK);
        #1;
        check("t4_txsend_drop", bus.TxSend, 0);
        idle(10);
        check("t4_tx_once", tx_count - tx0, 1);
        check("t4_txbyte_hold", bus.TxByte, ACK);

        // 5: asynchronous reset mid-payload
        q = {SYNC, 8'h04, 8'h11};
        send_seq(q);
        check("t5_pre_addr", bus.WrData, 8'h11);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_WrEn", bus.WrEn, 0);
        check("t5_WrData", bus.WrData, 0);
        check("t5_WrAddr", bus.WrAddr, 0);
        check("t5_TxByte", bus.TxByte, 0);
        check("t5_FrameErr", bus.FrameErr, 0);
        idle(3);
        Reset_n = 1'b1;
        idle(2);
        snap();
        q = {SYNC, 8'h01, 8'h7F, 8'h7F};
        send_seq(q);
        idle(4);
        check("t5_wr", wr_count - wr0, 1);
        check("t5_txbyte", last_tx, ACK);

        // len=255 boundary
        snap();
        q = {SYNC, 8'hFF};
        for (int i = 0; i < 255; i++) q.push_back(8'(i));
        q.push_back(8'h81);
        send_seq(q);
        idle(4);
        check("l255_wr_count", wr_count - wr0, 255);
        check("l255_last_addr", wr_addr_log[254], 8'hFE);
        check("l255_last_data", wr_data_log[254], 8'hFE);
        check("l255_done", done_count - done0, 1);
        check("l255_txbyte", last_tx, ACK);

`ifdef FRAME_TIMEOUT_EN
        // 6: stalled frame times out without a response
        snap();
        q = {SYNC, 8'h05};
        send_seq(q);
        idle(TO + 10);
        check("t6_err", err_count - err0, 1);
        check("t6_no_tx", tx_count - tx0, 0);
        q = {SYNC, 8'h01, 8'h01, 8'h01};
        send_seq(q);
        idle(4);
        check("t6_recover_tx", tx_count - tx0, 1);
        check("t6_recover_txbyte", last_tx, ACK);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
